// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the PC sequencer slice.
//   XLEN         datapath width
//   BR_*         3-bit branch codes from the execute stage
//   pc_state_e   sequencer FSM states
//   ex_res_t     execute-stage result bundle consumed by the next-PC select
package pc_seq_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] BR_SEQ  = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_UND  = 3'b011;  // undefined, behaves as BR_SEQ
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    HOLD  = 2'd3
  } pc_state_e;

  typedef struct packed {
    logic [2:0]      branch;
    logic            zero;
    logic            less;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
  } ex_res_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the imem fetch handshake, the decode/execute
// handshake and the PC/trap status outputs of the sequencer.
//   master: the sequencer (drives imem_req/addr, instr, pc, status)
//   slave : imem + execute datapath (drives imem_ready/rdata, ex_* results, stall)
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  // imem fetch
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  // decode / execute
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic            ex_done;
  logic [2:0]      branch;
  logic            zero;
  logic            less;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            stall;
  // status
  logic [XLEN-1:0] pc;
  logic            redirect;
  logic            trap;
  logic [XLEN-1:0] trap_epc;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, redirect, trap, trap_epc,
    input  imem_ready, imem_rdata, ex_done, branch, zero, less, imm, rs1, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, redirect, trap, trap_epc,
    output imem_ready, imem_rdata, ex_done, branch, zero, less, imm, rs1, stall
  );

endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC resolution.
//   pc      in   current instruction PC
//   ex      in   execute result (branch code, zero/less flags, imm, rs1)
//   taken   out  control transfer taken
//   seq_pc  out  pc + 4 (sequential successor)
//   target  out  resolved target, bit0 cleared for jalr; alignment of
//                bits [1:0] is left to the caller
module pc_next_sel
  import pc_seq_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  ex_res_t         ex,
  output logic            taken,
  output logic [XLEN-1:0] seq_pc,
  output logic [XLEN-1:0] target
);

  logic            is_jalr;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] sum;

  always_comb begin
    taken = 1'b0;
    unique case (ex.branch)
      BR_JAL,
      BR_JALR: taken = 1'b1;
      BR_BEQ:  taken = ex.zero;
      BR_BNE:  taken = ~ex.zero;
      BR_BLT:  taken = ex.less;
      BR_BGE:  taken = ~ex.less;
      default: taken = 1'b0;  // BR_SEQ and the undefined code
    endcase
  end

  assign is_jalr = (ex.branch == BR_JALR);
  assign op_a    = taken   ? ex.imm : XLEN'(4);
  assign op_b    = is_jalr ? ex.rs1 : pc;
  assign sum     = op_a + op_b;  // wraps mod 2^32 by width
  assign seq_pc  = pc + XLEN'(4);
  assign target  = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/PC controller for the RV32 core.
// Owns the PC, fetches from imem, issues each instruction to execute, then
// resolves the next PC from the execute stage's branch result.
//   clk, rst           clock, synchronous active-high reset
//   bus (master)       imem_req/addr/ready/rdata fetch handshake,
//                      instr/instr_valid issue, ex_done/branch/zero/less/imm/rs1
//                      execute result, stall, pc/redirect/trap/trap_epc status
// Optional: define PC_MISALIGN_TRAP_EN to redirect misaligned targets to
// TRAP_PC with a trap pulse; otherwise target bits [1:0] are forced to 00 and
// trap/trap_epc stay 0.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_001C
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.master  bus
);

  pc_state_e       state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            vld_q;
  logic            redir_q;
  logic            trap_q;
  logic [XLEN-1:0] epc_q;

  ex_res_t         ex;
  logic            taken;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target;
  logic            mis;
  logic [XLEN-1:0] next_pc;
  logic            redir_nx;

  assign ex = '{branch: bus.branch, zero: bus.zero, less: bus.less,
                imm: bus.imm, rs1: bus.rs1};

  pc_next_sel u_sel (
    .pc     (pc_q),
    .ex     (ex),
    .taken  (taken),
    .seq_pc (seq_pc),
    .target (target)
  );

  always_comb begin
`ifdef PC_MISALIGN_TRAP_EN
    mis = |target[1:0];
`else
    mis = 1'b0;
`endif
    next_pc  = mis ? TRAP_PC : (target & ~XLEN'(3));
    // A trap always counts as a redirect even if TRAP_PC happens to equal pc+4.
    // A taken transfer landing on pc+4 is indistinguishable from sequential flow.
    redir_nx = mis | (next_pc != seq_pc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      vld_q   <= 1'b0;
      redir_q <= 1'b0;
      trap_q  <= 1'b0;
      epc_q   <= '0;
    end else begin
      vld_q   <= 1'b0;
      redir_q <= 1'b0;
      trap_q  <= 1'b0;
      unique case (state)
        FETCH: if (bus.imem_ready) begin
          instr_q <= bus.imem_rdata;
          state   <= ISSUE;
        end
        ISSUE: begin
          vld_q <= 1'b1;  // visible during the first EXEC cycle
          state <= EXEC;
        end
        EXEC: if (bus.ex_done) begin
          // PC resolves on the ex_done edge even when parking in HOLD.
          pc_q    <= next_pc;
          redir_q <= redir_nx;
          trap_q  <= mis;
          if (mis) epc_q <= pc_q;
          state   <= bus.stall ? HOLD : FETCH;
        end
        HOLD: if (!bus.stall) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.imem_req    = (state == FETCH) & ~rst;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc          = pc_q;
  assign bus.redirect    = redir_q;
  assign bus.trap        = trap_q;
  assign bus.trap_epc    = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(32'h0000_0000), .TRAP_PC(32'h0000_001C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nchk  = 0;
  int npass = 0;
  logic [31:0] p;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects FETCH on entry; leaves the DUT in its first EXEC cycle.
  // During imem wait cycles ex_done/stall are raised to show they are ignored.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int wait_cyc);
    chk("req", bus.imem_req, 1);
    chk("addr", bus.imem_addr, addr);
    for (int i = 0; i < wait_cyc; i++) begin
      bus.ex_done = 1'b1; bus.stall = 1'b1; bus.branch = BR_JAL; bus.imm = 32'h100;
      tick();
      chk("req_hold", bus.imem_req, 1);
      chk("addr_hold", bus.imem_addr, addr);
    end
    bus.ex_done = 1'b0; bus.stall = 1'b0;
    bus.imem_ready = 1'b1; bus.imem_rdata = word;
    tick();
    bus.imem_ready = 1'b0;
    chk("instr", bus.instr, word);
    chk("vld_issue", bus.instr_valid, 0);
    chk("req_issue", bus.imem_req, 0);
    tick();
    chk("vld_exec", bus.instr_valid, 1);
  endtask

  task automatic exec(input logic [2:0] br, input logic z, input logic l,
                      input logic [31:0] imm, input logic [31:0] rs1, input logic stl,
                      input logic [31:0] exp_pc, input logic exp_redir,
                      input logic exp_trap, input logic [31:0] exp_epc);
    bus.branch = br; bus.zero = z; bus.less = l; bus.imm = imm; bus.rs1 = rs1;
    bus.stall = stl; bus.ex_done = 1'b1;
    tick();
    bus.ex_done = 1'b0;
    chk("pc", bus.pc, exp_pc);
    chk("redirect", bus.redirect, exp_redir);
    chk("trap", bus.trap, exp_trap);
    chk("trap_epc", bus.trap_epc, exp_epc);
    if (stl) begin
      chk("hold_req0", bus.imem_req, 0);
      tick();
      chk("hold_req1", bus.imem_req, 0);
      chk("hold_redir", bus.redirect, 0);
      bus.stall = 1'b0;
      tick();
      chk("hold_exit", bus.imem_req, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.ex_done = 1'b0;
    bus.branch = BR_SEQ; bus.zero = 1'b0; bus.less = 1'b0;
    bus.imm = '0; bus.rs1 = '0; bus.stall = 1'b0;
    tick();
    tick();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_vld", bus.instr_valid, 0);
    chk("rst_redir", bus.redirect, 0);
    chk("rst_trap", bus.trap, 0);
    chk("rst_epc", bus.trap_epc, 32'h0);
    rst = 1'b0;
    #1;

    // first fetch, zero-wait imem; jal to 0x40
    fetch(32'h0, 32'h0050_0093, 0);
    exec(BR_JAL, 0, 0, 32'h40, 0, 0, 32'h40, 1, 0, 0);
    // beq taken
    fetch(32'h40, 32'h0000_0463, 0);
    exec(BR_BEQ, 1, 0, 32'h10, 0, 0, 32'h50, 1, 0, 0);
    tick();
    chk("redir_pulse", bus.redirect, 0);
    chk("vld_pulse", bus.instr_valid, 0);
    // back to 0x40 (imem_ready was low that cycle), then beq not taken
    fetch(32'h50, 32'h0000_0013, 0);
    exec(BR_JAL, 0, 0, 32'hFFFF_FFF0, 0, 0, 32'h40, 1, 0, 0);
    fetch(32'h40, 32'h0000_0463, 0);
    exec(BR_BEQ, 0, 0, 32'h10, 0, 0, 32'h44, 0, 0, 0);
    // to 0x80, then jalr with stall into HOLD
    fetch(32'h44, 32'h0000_0013, 0);
    exec(BR_JAL, 0, 0, 32'h3C, 0, 0, 32'h80, 1, 0, 0);
    fetch(32'h80, 32'h0040_8067, 0);
    exec(BR_JALR, 0, 0, 32'h4, 32'h1001, 1, 32'h1004, 1, 0, 0);
    // to top of address space, slow imem, sequential wrap to 0
    fetch(32'h1004, 32'h0000_0013, 0);
    exec(BR_JALR, 0, 0, 32'h4, 32'hFFFF_FFF8, 0, 32'hFFFF_FFFC, 1, 0, 0);
    fetch(32'hFFFF_FFFC, 32'h0000_0013, 3);
    exec(BR_SEQ, 0, 0, 32'h40, 0, 0, 32'h0, 0, 0, 0);
    // misaligned jal from 0x20
    fetch(32'h0, 32'h0000_006F, 0);
    exec(BR_JAL, 0, 0, 32'h20, 0, 0, 32'h20, 1, 0, 0);
    fetch(32'h20, 32'h0000_006F, 0);
`ifdef PC_MISALIGN_TRAP_EN
    exec(BR_JAL, 0, 0, 32'h6, 0, 0, 32'h1C, 1, 1, 32'h20);
    p = 32'h1C;
`else
    exec(BR_JAL, 0, 0, 32'h6, 0, 0, 32'h24, 0, 0, 0);
    p = 32'h24;
`endif
    // undefined code, bne, blt, bge not taken, bge taken
    fetch(p, 32'h0000_0013, 0);
    exec(BR_UND, 1, 1, 32'h100, 0, 0, p + 32'h4, 0, 0, bus.trap_epc);
    p = p + 32'h4;
    fetch(p, 32'h0000_1463, 0);
    exec(BR_BNE, 0, 0, 32'h8, 0, 0, p + 32'h8, 1, 0, bus.trap_epc);
    p = p + 32'h8;
    fetch(p, 32'h0000_4663, 0);
    exec(BR_BLT, 0, 1, 32'hC, 0, 0, p + 32'hC, 1, 0, bus.trap_epc);
    p = p + 32'hC;
    fetch(p, 32'h0000_5063, 0);
    exec(BR_BGE, 0, 1, 32'h40, 0, 0, p + 32'h4, 0, 0, bus.trap_epc);
    p = p + 32'h4;
    fetch(p, 32'h0000_5863, 0);
    exec(BR_BGE, 0, 0, 32'h10, 0, 0, p + 32'h10, 1, 0, bus.trap_epc);
    p = p + 32'h10;

    // reset in EXEC with ex_done asserted
    fetch(p, 32'h0000_006F, 0);
    rst = 1'b1; bus.ex_done = 1'b1; bus.branch = BR_JAL; bus.imm = 32'h40;
    tick();
    chk("rstx_pc", bus.pc, 32'h0);
    chk("rstx_redir", bus.redirect, 0);
    chk("rstx_req", bus.imem_req, 0);
    chk("rstx_epc", bus.trap_epc, 32'h0);
    rst = 1'b0; bus.ex_done = 1'b0;
    #1;
    chk("rstx_fetch", bus.imem_req, 1);
    chk("rstx_addr", bus.imem_addr, 32'h0);
    tick();
    chk("rstx_redir2", bus.redirect, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
